// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: data widths, the
// NOP returned on errors, FSM state type and the built-in program image.
package imem_responder_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Program image held by the ROM: word i is "addi x((i%31)+1), x0, i+5".
  // Word 0 is therefore 32'h00500093.
  function automatic logic [INSTR_W-1:0] rom_image(input logic [31:0] idx);
    logic [31:0] rd;
    rd = (idx % 32'd31) + 32'd1;
    return ((idx + 32'd5) << 20) | (rd << 7) | 32'h0000_0013;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch <-> instruction-memory bus: request channel (valid/ready + address),
// flush (redirect) and response channel (valid/ready + instr/addr/err).
//   master : fetch stage side
//   slave  : imem_responder side
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [XLEN-1:0]    req_addr;
  logic               flush;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [INSTR_W-1:0] rsp_instr;
  logic [XLEN-1:0]    rsp_addr;
  logic               rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

endinterface

// File: rtl/imem_responder_rom.sv
// imem_rom: synchronous-read instruction ROM, IMEM_WORDS x 32.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset (read register only, not the array)
//   en   in   read enable; data is registered on the enabling edge
//   addr in   word index
//   data out  registered read data (NOP after reset)
module imem_rom
  import imem_responder_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter string       INIT_FILE  = "imem.hex",
  localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [AW-1:0]      addr,
  output logic [INSTR_W-1:0] data
);

  // Contents come from the packaged program image; an empty image name
  // yields an all-zero ROM.
  localparam bit IMAGE_EN = (INIT_FILE != "");

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= NOP_INSTR;
    end else if (en) begin
      data <= IMAGE_EN ? rom_image(32'(addr)) : '0;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: serves fetch-stage instruction reads with a fixed latency.
// One request is accepted at a time; the response appears LATENCY edges after
// accept and is held until consumed. flush cancels any in-flight/held response.
// Ports:
//   clk  in      rising-edge clock
//   rst  in      synchronous active-high reset
//   bus  slave   request / flush / response channels (imem_responder_if)
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned     IMEM_WORDS = 256,
  parameter logic [XLEN-1:0] BASE_ADDR  = '0,
  parameter int unsigned     LATENCY    = 2,   // legal range 1..15
  parameter string           INIT_FILE  = "imem.hex"
) (
  input logic               clk,
  input logic               rst,
  imem_responder_if.slave   bus
);

  localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  state_t          state, state_n;
  logic [3:0]      cnt;
  logic [XLEN-1:0] addr_q;
  logic            err_q;
  logic            accept;
  logic            req_err;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] word_idx;
  logic [INSTR_W-1:0] rom_data;

  // Any borrow in the base subtraction is an error, so no wrap is valid.
  always_comb begin
    offset   = bus.req_addr - BASE_ADDR;
    word_idx = offset >> 2;
    req_err  = (bus.req_addr[1:0] != 2'b00)
            || (bus.req_addr < BASE_ADDR)
            || (word_idx >= XLEN'(IMEM_WORDS));
  end

  assign bus.req_ready = (state == ST_IDLE) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;

  imem_rom #(
    .IMEM_WORDS (IMEM_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .addr (word_idx[AW-1:0]),
    .data (rom_data)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (accept) state_n = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (cnt == 4'd1) state_n = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (bus.flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= bus.req_addr;
        err_q  <= req_err;
        cnt    <= 4'(LATENCY - 1);
      end else if (bus.flush) begin
        cnt <= '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Address, error flag and ROM read register only change on accept, so the
  // response fields stay stable for the whole RESP hold.
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_addr  = addr_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_instr = err_q ? NOP_INSTR : rom_data;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned WORDS = 256;
  localparam logic [63:0] BASE  = 64'h0;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_responder_if bus ();

  imem_responder #(
    .IMEM_WORDS (WORDS),
    .BASE_ADDR  (BASE),
    .LATENCY    (LAT),
    .INIT_FILE  ("imem.hex")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] addr;
    int          hold;
    logic        err;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: address rules and program image ("addi x(i%31+1), x0, i+5").
  function automatic logic m_err(input logic [63:0] a);
    logic [63:0] off;
    if (a % 64'd4 != 64'd0) return 1'b1;
    if (a < BASE) return 1'b1;
    off = a - BASE;
    return (off / 64'd4) >= 64'(WORDS);
  endfunction

  function automatic logic [31:0] m_instr(input logic [63:0] a);
    logic [63:0] idx;
    if (m_err(a)) return NOP;
    idx = (a - BASE) / 64'd4;
    return {12'(idx + 64'd5), 5'd0, 3'd0, 5'((idx % 64'd31) + 64'd1), 7'h13};
  endfunction

  // Called at a negedge with the bus idle. Returns 1 when the request was accepted.
  task automatic do_accept(input logic [63:0] a, input string tag, output bit ok);
    int k;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.rsp_ready = 1'b0;
    #1;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = bus.req_ready;
    if (!ok) begin
      chk({tag, " accept timeout"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic txn(input logic [63:0] a, input int hold, input logic exp_err,
                     input logic [31:0] exp_instr, input string tag);
    int k;
    bit ok;
    do_accept(a, tag, ok);
    if (!ok) return;
    // rsp_valid is first seen in the cycle ending at edge accept+LAT,
    // i.e. LAT-1 negedges after the one following the accept edge.
    k = 0;
    while (!bus.rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(LAT - 1));
    chk({tag, " instr"}, 64'(bus.rsp_instr), 64'(exp_instr));
    chk({tag, " addr"},  bus.rsp_addr, a);
    chk({tag, " err"},   64'(bus.rsp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, " hold instr"}, 64'(bus.rsp_instr), 64'(exp_instr));
      chk({tag, " hold addr"},  bus.rsp_addr, a);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk({tag, " consumed"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, " idle ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  // Accept a request, wait d cycles, flush; the response must never show up.
  task automatic flush_txn(input logic [63:0] a, input int d, input string tag);
    bit ok;
    do_accept(a, tag, ok);
    if (!ok) return;
    repeat (d) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk({tag, " ready under flush"}, 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk({tag, " flushed valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, " flushed ready"}, 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      @(negedge clk);
      chk({tag, " no late rsp"}, 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] a;
    int          k;
    bit          ok;

    tbl[0] = '{64'h0,                  0, 1'b0, 32'h0050_0093};
    tbl[1] = '{64'h4,                  5, 1'b0, 32'h0060_0113};
    tbl[2] = '{64'h6,                  1, 1'b1, NOP};
    tbl[3] = '{64'h400,                0, 1'b1, NOP};
    tbl[4] = '{64'h3FC,                2, 1'b0, 32'h1040_0413};
    tbl[5] = '{64'h20,                 0, 1'b0, 32'h00D0_0493};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFC, 1, 1'b1, NOP};
    tbl[7] = '{64'h401,                0, 1'b1, NOP};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset rsp_instr", 64'(bus.rsp_instr), 64'(NOP));
    chk("reset req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset rsp_addr",  bus.rsp_addr, 64'd0);
    chk("reset rsp_err",   64'(bus.rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      txn(tbl[i].addr, tbl[i].hold, tbl[i].err, tbl[i].instr, $sformatf("vec%0d", i));

    // Flush one cycle after accept, then a fresh request is served normally.
    flush_txn(64'h8, 0, "flush");
    txn(64'h20, 0, 1'b0, 32'h00D0_0493, "after flush");

    // Request presented together with flush is not accepted.
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h10;
    bus.flush     = 1'b1;
    #1;
    chk("req+flush ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    #1;
    chk("req+flush not accepted", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      @(negedge clk);
      chk("req+flush no rsp", 64'(bus.rsp_valid), 64'd0);
    end

    // Reset while a response is held.
    do_accept(64'hC, "rst in resp", ok);
    if (ok) begin
      k = 0;
      while (!bus.rsp_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("rst in resp reached", 64'(bus.rsp_valid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst in resp valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst in resp instr", 64'(bus.rsp_instr), 64'(NOP));
      chk("rst in resp addr",  bus.rsp_addr, 64'd0);
      rst = 1'b0;
      @(negedge clk);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = BASE + 64'd4 * 64'($urandom_range(0, WORDS - 1));
        6:                a = BASE + 64'd4 * 64'($urandom_range(0, WORDS - 1))
                              + 64'($urandom_range(1, 3));
        7:                a = BASE + 64'd4 * 64'(WORDS + $urandom_range(0, 100));
        8:                a = {$urandom, $urandom};
        default:          a = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      if (a == 64'hFFFF_FFFF_FFFF_FFFF)
        flush_txn(BASE + 64'd4 * 64'($urandom_range(0, WORDS - 1)),
                  int'($urandom_range(0, LAT)), "rnd flush");
      else
        txn(a, int'($urandom_range(0, 3)), m_err(a), m_instr(a), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
